countdown_timer: RTL

- Programmable two-digit countdown timer (0..99) whose registered count output drives the binary input of the two-digit 7-segment decoder stage.
- Count decrements once per prescaled tick while running.
- Accepts load, start and stop controls; flags expiry when the count reaches zero.
- bin_out is guaranteed never to exceed 99, so the downstream decoder always receives a valid two-digit value.

---
 rtl/countdown_timer.sv | 103 ++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Two-digit (0..MAX_COUNT) countdown timer with a prescaled tick, load/start/stop
// controls and expiry flags; bin_out feeds the downstream 7-segment decoder.
module countdown_timer #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MAX_COUNT = 99
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic       start,
    input  logic       stop,
    output logic [6:0] bin_out,
    output logic       running,
    output logic       expired,
    output logic       done_pulse
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]    MAX_VAL    = 7'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [6:0]    count_reg, count_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          done_pulse_reg, done_pulse_next;
    logic          running_reg, expired_reg;

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        presc_next      = presc_reg;
        done_pulse_next = 1'b0;

        if (load) begin
            count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            presc_next = '0;
            state_next = IDLE;
        end else if (stop && state_reg == RUN) begin
            // Stop beats a coincident tick: the prescaler freezes at its last
            // value so the resumed run ticks on its very first cycle.
            state_next = PAUSE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && count_reg != 7'd0) begin
                        presc_next = '0;
                        state_next = RUN;
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (presc_reg == PRESC_LAST) begin
                        presc_next = '0;
                        if (count_reg <= 7'd1) begin
                            count_next      = 7'd0;
                            state_next      = DONE;
                            done_pulse_next = 1'b1;
                        end else begin
                            count_next = count_reg - 7'd1;
                        end
                    end else begin
                        presc_next = presc_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            count_reg      <= 7'd0;
            presc_reg      <= '0;
            done_pulse_reg <= 1'b0;
            running_reg    <= 1'b0;
            expired_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            presc_reg      <= presc_next;
            done_pulse_reg <= done_pulse_next;
            running_reg    <= (state_next == RUN);
            expired_reg    <= (state_next == DONE);
        end
    end

    assign bin_out    = count_reg;
    assign running    = running_reg;
    assign expired    = expired_reg;
    assign done_pulse = done_pulse_reg;
endmodule
